bus_write_checker: RTL
======================

// Module: bus_write_checker
// PURPOSE
//  Synthesizable self-check monitor for processor regression runs.
//  - Snoops memory write traffic (wr_en/wr_addr/wr_data) from the CPU-to-memory bus.
//  - Compares those writes against a table of N_CHECKS expected (address, data) pairs.
//  - Reports done/pass/fail, a failure code, the failing entry and the cycle count.
//  - Replaces a fixed-delay, single-location RAM check with a cycle-accurate, multi-point checker.
// PARAMETERS
//  ADDR_W    16  width of the snooped address bus
//  DATA_W    8   width of the snooped data bus
//  N_CHECKS  4   number of expected (addr, data) entries; must be >= 1
//  TIMEOUT   50  cycles in RUN before an unfinished check fails
//  CNT_W     $clog2(TIMEOUT+1)  cycle counter width (derived; do not override)
//  IDX_W     (N_CHECKS>1) ? $clog2(N_CHECKS) : 1  entry index width (derived)
// PORTS
//  ph2        in   1                  single system clock; all state updates on rising edge
//  reset_b    in   1                  asynchronous, active-low reset
//  start      in   1                  arm the checker (honoured in IDLE/PASS/FAIL only)
//  ordered    in   1                  1 = entries must be satisfied in index order; sampled on start
//  check_en   in   N_CHECKS           per-entry enable; sampled on start
//  exp_addr   in   N_CHECKS*ADDR_W    expected addresses, entry i at [i*ADDR_W +: ADDR_W]
//  exp_data   in   N_CHECKS*DATA_W    expected data, entry i at [i*DATA_W +: DATA_W]
//  wr_en      in   1                  a bus write is valid this cycle
//  wr_addr    in   ADDR_W             write address
//  wr_data    in   DATA_W             write data
//  done       out  1                  1 in PASS or FAIL
//  pass       out  1                  1 in PASS
//  fail       out  1                  1 in FAIL
//  fail_code  out  2                  00 none, 01 data mismatch, 10 out of order, 11 timeout
//  fail_idx   out  IDX_W              entry that caused FAIL; 0 otherwise
//  matched    out  N_CHECKS           sticky per-entry "satisfied" flags
//  cycles     out  CNT_W              cycles spent in RUN; frozen once done
// BEHAVIOUR
//  Reset (reset_b = 0, asynchronous, any time including mid-RUN):
//   - state goes to IDLE.
//   - all outputs, the pending mask and the mode register go to 0.
//  FSM states: IDLE, RUN, PASS, FAIL.
//  Arming (start=1 in IDLE, PASS or FAIL):
//   - next state is RUN; pending <= check_en; mode <= ordered.
//   - matched, cycles, fail_code and fail_idx clear to 0.
//   - start is ignored while in RUN.
//  RUN, every cycle:
//   - cycles increments; it saturates at TIMEOUT.
//   - hit[i] = pending[i] & wr_en & (wr_addr == exp_addr[i]).
//   - Unordered mode, hit[i] with data equal: clear pending[i] and set matched[i].
//     Several entries may match in the same cycle.
//   - Unordered mode, hit[i] with data unequal: go to FAIL, code 01,
//     fail_idx = lowest such i. A mismatch outranks matches in the same cycle.
//   - Ordered mode: only the lowest pending index h is eligible.
//     A hit on h with equal data matches it; with unequal data -> FAIL, code 01, idx h.
//     A hit on any other pending entry -> FAIL, code 10, idx = that entry (lowest if several).
//   - Writes to already-matched or disabled entries are ignored; matched is sticky.
//  Completion:
//   - When pending becomes 0, the next state is PASS (registered, one cycle after the final matching write).
//   - If cycles == TIMEOUT-1 while pending remains nonzero after this cycle's updates -> FAIL, code 11,
//     fail_idx = lowest pending index.
//   - If the final match and the timeout fall in the same cycle, PASS wins.
//   - start with check_en == 0 -> PASS after exactly one RUN cycle (cycles = 1).
//  PASS and FAIL hold until a new start or a reset. Outputs are registered, never combinational from inputs.
// STRUCTURE
//  - Shared package bwc_pkg holds:
//    - the state enum (IDLE, RUN, PASS, FAIL).
//    - the fail_code enum (FC_NONE, FC_DATA, FC_ORDER, FC_TIMEOUT).
//  - One sub-module, bwc_prio_enc #(N): lowest-set-bit priority encoder (valid + index). It is instantiated for:
//    - the lowest pending index.
//    - the mismatch select.
//    - the out-of-order select.
//  - Top level contains the per-entry compare generate loop, the FSM and the counter.
// TESTING
//  - N=4, TIMEOUT=50, unordered, check_en=0001, exp[0]=(0x0040,0x42):
//    write 0x42 to 0x0040 at RUN cycle 10 -> pass=1 at cycle 11, matched=0001, cycles=11.
//  - Same setup, write 0x41 to 0x0040 -> fail=1 next cycle, fail_code=01, fail_idx=0.
//  - Ordered, check_en=0011, exp[0]=(0x10,0xAA), exp[1]=(0x11,0xBB):
//    write 0x11 first -> FAIL, code 10, idx 1.
//    Repeat with 0x10 then 0x11 -> PASS, matched=0011.
//  - check_en=0100, no matching write:
//    -> FAIL exactly when cycles reaches 50, code 11, idx 2, cycles frozen at 50.
//  - Final match on the timeout cycle -> PASS.
//    start with check_en=0 -> PASS, cycles=1.
//  - Pull reset_b low mid-RUN -> outputs 0 immediately, state IDLE.
//    Then start -> clean rerun that passes.

Source files
------------

// File: rtl/bwc_pkg.sv
// Shared types for the bus write checker: FSM states and failure codes.
package bwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_DATA    = 2'b01,
    FC_ORDER   = 2'b10,
    FC_TIMEOUT = 2'b11
  } fc_t;

endpackage

// File: rtl/bwc_prio_enc.sv
// Lowest-set-bit priority encoder: valid when any request is set, idx of the lowest one.
module bwc_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/bus_write_checker.sv
// Snoops bus writes and checks them against a table of expected (addr, data) pairs,
// reporting pass/fail, the failure reason and entry, and the cycles spent running.
module bus_write_checker
  import bwc_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int N_CHECKS = 4,
  parameter int TIMEOUT  = 50
) (
  input  logic                                              ph2,
  input  logic                                              reset_b,
  input  logic                                              start,
  input  logic                                              ordered,
  input  logic [N_CHECKS-1:0]                               check_en,
  input  logic [N_CHECKS*ADDR_W-1:0]                        exp_addr,
  input  logic [N_CHECKS*DATA_W-1:0]                        exp_data,
  input  logic                                              wr_en,
  input  logic [ADDR_W-1:0]                                 wr_addr,
  input  logic [DATA_W-1:0]                                 wr_data,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              fail,
  output logic [1:0]                                        fail_code,
  output logic [((N_CHECKS > 1) ? $clog2(N_CHECKS) : 1)-1:0] fail_idx,
  output logic [N_CHECKS-1:0]                               matched,
  output logic [$clog2(TIMEOUT + 1)-1:0]                    cycles
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [N_CHECKS-1:0] pending_r;
  logic                mode_r;
  logic [N_CHECKS-1:0] hit_s;
  logic [N_CHECKS-1:0] eq_s;
  logic [N_CHECKS-1:0] head_s;
  logic [N_CHECKS-1:0] good_s;
  logic [N_CHECKS-1:0] mis_req_s;
  logic [N_CHECKS-1:0] ord_req_s;
  logic [N_CHECKS-1:0] pending_nxt_s;
  logic                mis_v_s;
  logic                ord_v_s;
  logic                left_v_s;
  logic [IDX_W-1:0]    mis_idx_s;
  logic [IDX_W-1:0]    ord_idx_s;
  logic [IDX_W-1:0]    left_idx_s;
  logic                last_cycle_s;

  for (genvar g = 0; g < N_CHECKS; g++) begin : g_cmp
    assign hit_s[g] = pending_r[g] & wr_en & (wr_addr == exp_addr[g*ADDR_W +: ADDR_W]);
    assign eq_s[g]  = (wr_data == exp_data[g*DATA_W +: DATA_W]);
  end

  // One-hot of the lowest pending entry: the only one eligible in ordered mode.
  assign head_s        = pending_r & ~(pending_r - N_CHECKS'(1));
  assign good_s        = mode_r ? (hit_s & eq_s & head_s) : (hit_s & eq_s);
  assign mis_req_s     = mode_r ? (hit_s & ~eq_s & head_s) : (hit_s & ~eq_s);
  assign ord_req_s     = mode_r ? (hit_s & ~head_s) : {N_CHECKS{1'b0}};
  assign pending_nxt_s = pending_r & ~good_s;
  assign last_cycle_s  = (cycles == CNT_W'(TIMEOUT - 1));

  bwc_prio_enc #(.N(N_CHECKS), .IW(IDX_W)) u_enc_left (
    .req   (pending_nxt_s),
    .valid (left_v_s),
    .idx   (left_idx_s)
  );

  bwc_prio_enc #(.N(N_CHECKS), .IW(IDX_W)) u_enc_mis (
    .req   (mis_req_s),
    .valid (mis_v_s),
    .idx   (mis_idx_s)
  );

  bwc_prio_enc #(.N(N_CHECKS), .IW(IDX_W)) u_enc_ord (
    .req   (ord_req_s),
    .valid (ord_v_s),
    .idx   (ord_idx_s)
  );

  // State register.
  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a completed table beats a simultaneous timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, PASS, FAIL: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (mis_v_s || ord_v_s) begin
          state_nxt_s = FAIL;
        end else if (!left_v_s) begin
          state_nxt_s = PASS;
        end else if (last_cycle_s) begin
          state_nxt_s = FAIL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Status decode straight off the state register.
  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    case (state_r)
      PASS:    begin done = 1'b1; pass = 1'b1; end
      FAIL:    begin done = 1'b1; fail = 1'b1; end
      default: begin done = 1'b0; end
    endcase
  end

  // Datapath: arming, per-entry tracking, cycle counter and failure capture.
  always_ff @(posedge ph2 or negedge reset_b) begin
    if (!reset_b) begin
      pending_r <= '0;
      mode_r    <= 1'b0;
      matched   <= '0;
      cycles    <= '0;
      fail_code <= FC_NONE;
      fail_idx  <= '0;
    end else begin
      case (state_r)
        IDLE, PASS, FAIL: begin
          if (start) begin
            pending_r <= check_en;
            mode_r    <= ordered;
            matched   <= '0;
            cycles    <= '0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
          end else begin
            pending_r <= pending_r;
          end
        end
        RUN: begin
          if (cycles != CNT_W'(TIMEOUT)) begin
            cycles <= cycles + CNT_W'(1);
          end else begin
            cycles <= cycles;
          end
          if (mis_v_s) begin
            fail_code <= FC_DATA;
            fail_idx  <= mis_idx_s;
          end else if (ord_v_s) begin
            fail_code <= FC_ORDER;
            fail_idx  <= ord_idx_s;
          end else begin
            pending_r <= pending_nxt_s;
            matched   <= matched | good_s;
            if (left_v_s && last_cycle_s) begin
              fail_code <= FC_TIMEOUT;
              fail_idx  <= left_idx_s;
            end else begin
              fail_code <= fail_code;
            end
          end
        end
        default: begin
          pending_r <= '0;
        end
      endcase
    end
  end

endmodule
